// File: rtl/sig_trace_buffer.sv
// sig_trace_buffer
// Capture-side trace buffer for the VGA waveform renderer. ADC samples are
// box-averaged into display points, stored in a circular block RAM, and read
// back oldest-first through the renderer's sig_addr/sig_data port. The unroll
// origin and visible point count are latched on frame_start so a frame never
// tears while new points keep arriving.

module sig_trace_buffer #(
    parameter logic [11:0] BASE_ADDR    = 12'h559,
    parameter int          DEPTH        = 320,
    parameter int          DECIM_LOG2   = 2,
    parameter int          SAMPLE_WIDTH = 12
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    sample_valid,
    input  logic [SAMPLE_WIDTH-1:0] sample_data,
    input  logic                    freeze,
    input  logic                    frame_start,
    input  logic [11:0]             sig_addr,
    output logic [31:0]             sig_data,
    output logic                    point_strobe,
    output logic                    filled
);

    // Widths derived from the parameters. The sample counter keeps at least
    // one bit so DECIM_LOG2 = 0 (no averaging) still elaborates cleanly; in
    // that case every accepted sample is the last one of its group.
    localparam int ACC_W = SAMPLE_WIDTH + DECIM_LOG2;
    localparam int CNT_W = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int WC_W  = $clog2(DEPTH + 1);
    localparam int SUM_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'((1 << DECIM_LOG2) - 1);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);
    localparam logic [WC_W-1:0]  WC_FULL   = WC_W'(DEPTH);
    localparam logic [SUM_W-1:0] SUM_DEPTH = SUM_W'(DEPTH);
    localparam logic [12:0]      BASE_EXT  = {1'b0, BASE_ADDR};
    localparam logic [12:0]      END_EXT   = 13'(BASE_ADDR) + 13'(DEPTH);

    // Accumulator state
    logic [ACC_W-1:0]        r_acc;
    logic [CNT_W-1:0]        r_cnt;

    // Write side state
    logic [PTR_W-1:0]        r_wrPtr;
    logic [WC_W-1:0]         r_wrCount;
    logic                    r_pointStrobe;

    // Per-frame snapshot used by the read side
    logic [PTR_W-1:0]        r_dispBase;
    logic [WC_W-1:0]         r_dispCount;

    // Read side state
    logic                    r_rdValid;
    logic [SAMPLE_WIDTH-1:0] r_rdData;

    // Point storage, intentionally without reset so it maps onto block RAM
    logic [SAMPLE_WIDTH-1:0] r_mem [DEPTH];

    // Combinational helpers
    logic                    w_accept;
    logic                    w_lastSample;
    logic                    w_writePoint;
    logic [ACC_W-1:0]        w_accSum;
    logic [SAMPLE_WIDTH-1:0] w_point;
    logic                    w_filled;
    logic [12:0]             w_addrExt;
    logic [12:0]             w_idx;
    logic                    w_inRange;
    logic [SUM_W-1:0]        w_physSum;
    logic [PTR_W-1:0]        w_phys;

    // A sample counts only when valid and not frozen; the final sample of a
    // group is folded into the sum and the truncated average is written out.
    assign w_accept     = sample_valid && !freeze;
    assign w_lastSample = (r_cnt == CNT_LAST);
    assign w_writePoint = w_accept && w_lastSample;
    assign w_accSum     = r_acc + ACC_W'(sample_data);
    assign w_point      = SAMPLE_WIDTH'(w_accSum >> DECIM_LOG2);
    assign w_filled     = (r_wrCount == WC_FULL);

    // Read address decode. The address is widened by one bit so that a
    // window ending past 12'hFFF still compares correctly. Only indices
    // below the latched count are visible, which also hides unwritten RAM.
    assign w_addrExt = {1'b0, sig_addr};
    assign w_idx     = w_addrExt - BASE_EXT;
    assign w_inRange = (w_addrExt >= BASE_EXT) && (w_addrExt < END_EXT)
                       && (w_idx < 13'(r_dispCount));

    // Unroll from the oldest entry. Both operands are below DEPTH when the
    // address is in range, so one conditional subtract replaces a modulo.
    assign w_physSum = SUM_W'(r_dispBase) + SUM_W'(w_idx);
    assign w_phys    = (w_physSum >= SUM_DEPTH) ? PTR_W'(w_physSum - SUM_DEPTH)
                                                : PTR_W'(w_physSum);

    // Box-average accumulator; freeze holds any partial sum untouched.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_accept) begin
            if (w_lastSample) begin
                r_acc <= '0;
                r_cnt <= '0;
            end else begin
                r_acc <= w_accSum;
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // Circular write pointer, saturating fill count and the point strobe.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wrPtr       <= '0;
            r_wrCount     <= '0;
            r_pointStrobe <= 1'b0;
        end else begin
            r_pointStrobe <= w_writePoint;
            if (w_writePoint) begin
                r_wrPtr <= (r_wrPtr == PTR_LAST) ? '0 : r_wrPtr + PTR_W'(1);
                if (!w_filled) begin
                    r_wrCount <= r_wrCount + WC_W'(1);
                end
            end
        end
    end

    // Frame snapshot of origin and visible count; pre-write values are
    // captured when a point lands on the same edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_dispBase  <= '0;
            r_dispCount <= '0;
        end else if (frame_start) begin
            r_dispBase  <= w_filled ? r_wrPtr : '0;
            r_dispCount <= r_wrCount;
        end
    end

    // Simple dual-port RAM with read-first behaviour on address collision.
    always_ff @(posedge clock) begin
        if (w_writePoint) begin
            r_mem[r_wrPtr] <= w_point;
        end
        r_rdData <= r_mem[w_phys];
    end

    // Registered in-range flag that masks the RAM output to zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rdValid <= 1'b0;
        end else begin
            r_rdValid <= w_inRange;
        end
    end

    // Zero-extend the stored point onto the 32-bit renderer bus.
    always_comb begin
        sig_data = '0;
        if (r_rdValid) begin
            sig_data[SAMPLE_WIDTH-1:0] = r_rdData;
        end
    end

    assign point_strobe = r_pointStrobe;
    assign filled       = w_filled;

endmodule

// File: tb/tb_sig_trace_buffer.sv
// Directed testbench for sig_trace_buffer: table-driven read checks per
// phase, plus hand-written sequences for averaging, freeze, same-cycle
// frame latch, reset mid-accumulation, wrap-around and read-first collision.

module tb_sig_trace_buffer;

    localparam logic [11:0] BASE = 12'h559;

    logic        clock;
    logic        reset;
    logic        sample_valid;
    logic [11:0] sample_data;
    logic        freeze;
    logic        frame_start;
    logic [11:0] sig_addr;
    logic [31:0] sig_data;
    logic        point_strobe;
    logic        filled;

    int checkCount  = 0;
    int errorCount  = 0;
    int strobeCount = 0;
    int strobeBase;

    typedef struct {
        int          phase;
        logic [11:0] addr;
        logic [31:0] expData;
        string       name;
    } readVec_t;

    readVec_t vecs[$];

    sig_trace_buffer dut (
        .clock        (clock),
        .reset        (reset),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .freeze       (freeze),
        .frame_start  (frame_start),
        .sig_addr     (sig_addr),
        .sig_data     (sig_data),
        .point_strobe (point_strobe),
        .filled       (filled)
    );

    // 100 MHz clock
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Count every cycle in which the strobe is high
    always @(posedge clock) begin
        if (point_strobe) strobeCount++;
    end

    // Hard stop in case the sequence ever stalls
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [11:0] value);
        sample_valid = 1'b1;
        sample_data  = value;
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic feedPoint(input logic [11:0] value);
        for (int i = 0; i < 4; i++) applyStimulus(value);
    endtask

    task automatic pulseFrame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic runReads(input int phase);
        foreach (vecs[i]) begin
            if (vecs[i].phase == phase) begin
                sig_addr = vecs[i].addr;
                tick();
                checkOutput(vecs[i].name, sig_data, vecs[i].expData);
            end
        end
    endtask

    task automatic addVec(input int phase, input logic [11:0] addr,
                          input logic [31:0] expData, input string name);
        readVec_t v;
        v.phase   = phase;
        v.addr    = addr;
        v.expData = expData;
        v.name    = name;
        vecs.push_back(v);
    endtask

    initial begin
        // Read vectors per phase
        addVec(0, BASE,    32'h0,   "p0_base_empty");
        addVec(0, 12'h000, 32'h0,   "p0_addr0_empty");
        addVec(1, BASE,    32'h280, "p1_avg_point");
        addVec(1, 12'h558, 32'h0,   "p1_below_base");
        addVec(1, 12'h55A, 32'h0,   "p1_idx_ge_count");
        addVec(1, 12'h699, 32'h0,   "p1_base_plus_depth");
        addVec(1, 12'hFFF, 32'h0,   "p1_top_addr");
        addVec(2, BASE,    32'h280, "p2_point1");
        addVec(2, 12'h55A, 32'h028, "p2_freeze_point");
        addVec(2, 12'h55B, 32'h0,   "p2_beyond");
        addVec(3, 12'h55C, 32'h444, "p3_point4");
        addVec(3, 12'h55D, 32'h0,   "p3_point5_hidden");
        addVec(4, 12'h55D, 32'h555, "p4_point5_visible");
        addVec(4, 12'h55E, 32'h0,   "p4_beyond");
        addVec(5, BASE,    32'h040, "p5_after_reset_point");
        addVec(5, 12'h55A, 32'h0,   "p5_beyond");
        addVec(6, BASE,    32'd2,   "p6_wrap_oldest");
        addVec(6, 12'h696, 32'd319, "p6_wrap_317");
        addVec(6, 12'h697, 32'd320, "p6_wrap_318");
        addVec(6, 12'h698, 32'd321, "p6_wrap_319");
        addVec(6, 12'h699, 32'h0,   "p6_wrap_end");

        // Reset held with sample_valid high
        reset        = 1'b1;
        sample_valid = 1'b1;
        sample_data  = 12'hABC;
        freeze       = 1'b0;
        frame_start  = 1'b0;
        sig_addr     = BASE;
        tick(); tick(); tick();
        checkOutput("reset_sig_data", sig_data, 32'h0);
        checkOutput("reset_strobe", {31'b0, point_strobe}, 32'h0);
        checkOutput("reset_filled", {31'b0, filled}, 32'h0);
        reset        = 1'b0;
        sample_valid = 1'b0;
        tick();
        checkOutput("idle_strobe", {31'b0, point_strobe}, 32'h0);
        pulseFrame();
        runReads(0);

        // Averaging: (0x100+0x200+0x300+0x401)>>2 = 0x280
        strobeBase = strobeCount;
        applyStimulus(12'h100);
        applyStimulus(12'h200);
        applyStimulus(12'h300);
        checkOutput("avg_no_early_strobe", {31'b0, point_strobe}, 32'h0);
        applyStimulus(12'h401);
        checkOutput("avg_strobe_high", {31'b0, point_strobe}, 32'h1);
        sig_addr = BASE;
        tick();
        checkOutput("avg_not_before_frame", sig_data, 32'h0);
        checkOutput("avg_strobe_low", {31'b0, point_strobe}, 32'h0);
        checkOutput("avg_strobe_count", 32'(strobeCount - strobeBase), 32'd1);
        pulseFrame();
        runReads(1);
        checkOutput("avg_filled_low", {31'b0, filled}, 32'h0);

        // Freeze: only 0x010,0x020,0x030,0x041 count -> 0xA1>>2 = 0x28
        strobeBase = strobeCount;
        applyStimulus(12'h010);
        applyStimulus(12'h020);
        freeze = 1'b1;
        for (int i = 0; i < 10; i++) applyStimulus(12'hFFF);
        freeze = 1'b0;
        applyStimulus(12'h030);
        applyStimulus(12'h041);
        tick();
        checkOutput("freeze_strobe_count", 32'(strobeCount - strobeBase), 32'd1);
        pulseFrame();
        runReads(2);

        // Same-cycle frame latch and write of point #5
        feedPoint(12'h333);
        feedPoint(12'h444);
        applyStimulus(12'h555);
        applyStimulus(12'h555);
        applyStimulus(12'h555);
        sample_valid = 1'b1;
        sample_data  = 12'h555;
        frame_start  = 1'b1;
        tick();
        sample_valid = 1'b0;
        frame_start  = 1'b0;
        checkOutput("simul_strobe", {31'b0, point_strobe}, 32'h1);
        runReads(3);
        pulseFrame();
        runReads(4);

        // Reset mid-accumulation discards the partial sum
        applyStimulus(12'hFFF);
        applyStimulus(12'hFFF);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("midreset_filled", {31'b0, filled}, 32'h0);
        checkOutput("midreset_sig_data", sig_data, 32'h0);
        sig_addr = BASE;
        tick();
        checkOutput("midreset_count_cleared", sig_data, 32'h0);
        feedPoint(12'h040);
        pulseFrame();
        runReads(5);

        // Wrap: 322 points of value k
        reset = 1'b1;
        tick();
        reset = 1'b0;
        strobeBase = strobeCount;
        for (int k = 0; k < 322; k++) begin
            feedPoint(12'(k));
            if (k == 318) checkOutput("wrap_filled_at_319", {31'b0, filled}, 32'h0);
            if (k == 319) checkOutput("wrap_filled_at_320", {31'b0, filled}, 32'h1);
        end
        tick();
        checkOutput("wrap_strobe_count", 32'(strobeCount - strobeBase), 32'd322);
        pulseFrame();
        checkOutput("wrap_filled", {31'b0, filled}, 32'h1);
        runReads(6);

        // Read-first: write of the next point lands on phys 2 while reading it
        sig_addr = BASE;
        applyStimulus(12'h7AB);
        applyStimulus(12'h7AB);
        applyStimulus(12'h7AB);
        applyStimulus(12'h7AB);
        checkOutput("collide_read_first", sig_data, 32'd2);
        tick();
        checkOutput("collide_new_data", sig_data, 32'h7AB);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/sig_trace_buffer.md
# sig_trace_buffer

Capture-side trace buffer feeding the VGA waveform renderer. Accepts a stream of 12-bit ADC samples, box-averages them down to display points, and stores the points in a circular buffer of DEPTH entries. It serves the renderer's `sig_addr`/`sig_data` read port with the buffer unrolled oldest-first, so the plotted trace scrolls. The unroll origin is latched once per frame so a frame never tears.

## Interface
- `BASE_ADDR`, default 12'h559: first read address of the trace window.
- `DEPTH`, default 320: number of stored points. Range 2..1024.
- `DECIM_LOG2`, default 2: log2 of the number of samples averaged per point. Range 0..4.
- `SAMPLE_WIDTH`, default 12: width of the ADC sample.

Ports:
- `clock`  in  1  system clock (100 MHz); all logic on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `sample_valid`  in  1  `sample_data` is valid this cycle.
- `sample_data`  in  SAMPLE_WIDTH  unsigned ADC sample.
- `freeze`  in  1  level; while high, incoming samples are discarded.
- `frame_start`  in  1  single-cycle pulse at the start of each display frame.
- `sig_addr`  in  12  renderer read address.
- `sig_data`  out  32  registered read data, {20'b0, point[11:0]}.
- `point_strobe`  out  1  single-cycle pulse when a point is written.
- `filled`  out  1  high once DEPTH points have been written since reset.

## Operation
**Accumulator**
- `acc` is SAMPLE_WIDTH+DECIM_LOG2 bits wide; `cnt` is DECIM_LOG2 bits wide.
- On `sample_valid && !freeze`:
  - if `cnt` ≠ 2^DECIM_LOG2−1: `acc += sample_data`, `cnt += 1`;
  - otherwise: `point = (acc + sample_data) >> DECIM_LOG2` (truncating), write `mem[wr_ptr] <= point`, clear `acc` and `cnt`, pulse `point_strobe`.
- When `freeze` is high, the partial accumulation is held, not cleared.

**Write pointer**
- `wr_ptr` counts 0..DEPTH−1 and wraps to 0.
- `wr_count` saturates at DEPTH; `filled` = (`wr_count` == DEPTH).

**Frame latch**
- On `frame_start`: `disp_base <= filled ? wr_ptr : 0` (oldest entry) and `disp_count <= wr_count`.
- The latch uses pre-write values if a point write occurs in the same cycle.

**Read path**
- `idx = sig_addr − BASE_ADDR`.
- In range when `BASE_ADDR ≤ sig_addr < BASE_ADDR+DEPTH` and `idx < disp_count`.
- `phys = disp_base + idx`; subtract DEPTH if the sum is ≥ DEPTH. Single conditional subtract; no modulo operator.
- Out of range: next `sig_data` = 0.
- Read and write to the same `phys` in one cycle is read-first: old data is returned.

**Memory**
- Inferred simple dual-port block RAM, DEPTH × 12.
- Contents are not reset. Entries never written are masked by `disp_count`.

## Timing
- Reset values: `sig_data` = 0, `point_strobe` = 0, `filled` = 0.
- Reset also clears internal state: `acc` = 0, `cnt` = 0, `wr_ptr` = 0, `wr_count` = 0, `disp_base` = 0, `disp_count` = 0.
- Reset mid-accumulation discards the partial point.
- Read latency is 1 clock: `sig_addr` at edge N gives `sig_data` valid after edge N+1. The renderer samples on the 25 MHz enable, so 1 cycle of latency is absorbed.
- Point write latency is 1 clock: the RAM write and `point_strobe` occur on the edge after the final sample is accepted.
- A point is readable at the next `frame_start` after it is written, never earlier.
- `sample_valid` may be asserted every cycle; there is no backpressure.
- `frame_start` on consecutive cycles: each pulse re-latches; last one wins.
- `freeze` and `frame_start` are independent; the frame latch still operates while frozen.

## Test plan
- **Reset.** Assert reset with `sample_valid` high → `sig_data`=0, `point_strobe`=0, `filled`=0. Any `sig_addr` read returns 0 until the first point is written and a `frame_start` occurs.
- **Averaging.** Feed samples 0x100, 0x200, 0x300, 0x401, then `frame_start`, then read 12'h559 → `sig_data` = 0x00000280 one clock later; `point_strobe` pulses exactly once.
- **Range and unwritten masking.** With 1 point stored: read 12'h558 → 0; 12'h55A → 0 (`idx` ≥ `disp_count`); 12'h699 (BASE+DEPTH) → 0.
- **Wrap.** Write 322 points with values k = 0..321, then `frame_start` → `filled`=1, `disp_base`=2. Read BASE → 2; BASE+317 → 319; BASE+318 → 320; BASE+319 → 321.
- **Freeze.** Feed 2 samples, raise `freeze`, feed 10 samples, drop `freeze`, feed 2 samples → exactly one point, whose value is the average of the 4 unfrozen samples.
- **Simultaneous.** `frame_start` in the same cycle as the write of point #5 → the latched `disp_count` is 4, so BASE+4 reads 0. After the next `frame_start`, BASE+4 returns point #5.
